// File: rtl/inst_fetch_ctrl.sv
// Program counter and fetch sequencer for the single-cycle core's instruction ROM.
// Optional watchdog enabled by defining FETCH_WATCHDOG_EN.
module inst_fetch_ctrl #(
  parameter int A      = 10,
  parameter int OW     = 8,
  parameter int MAXCYC = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchAbs,
  input  logic [A-1:0]  Target,
  input  logic          BranchRel,
  input  logic [OW-1:0] Offset,
  output logic [A-1:0]  InstAddress,
  output logic          FetchValid,
  output logic          Ack,
  output logic          Fault,
  output logic          Timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state;
  logic [A-1:0] pc;
  logic         fault;
  logic [A-1:0] offset_sext;
  logic         wd_fire;

  // The signed cast makes the width cast sign-extend the offset.
  assign offset_sext = A'($signed(Offset));

`ifdef FETCH_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(MAXCYC - 1);

  logic [15:0] wd_count;
  logic        timeout;

  assign wd_fire = (state == ST_RUN) && (wd_count == WD_LAST) && !Start;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wd_count <= '0;
      timeout  <= 1'b0;
    end else if (Start) begin
      wd_count <= '0;
      timeout  <= 1'b0;
    end else if (state == ST_RUN) begin
      wd_count <= wd_count + 16'd1;
      if (wd_fire)
        timeout <= 1'b1;
    end
  end

  assign Timeout = timeout;
`else
  assign wd_fire = 1'b0;
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            pc    <= StartAddr;
            fault <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Only the highest-priority request takes effect; the rest are dropped.
          if (Start) begin
            pc    <= StartAddr;
            fault <= 1'b0;
          end else if (Halt || wd_fire) begin
            state <= ST_DONE;
          end else if (Stall) begin
            pc <= pc;
          end else if (BranchAbs) begin
            pc <= Target;
          end else if (BranchRel) begin
            pc <= pc + offset_sext;
          end else begin
            pc <= pc + 1'b1;
            if (pc == {A{1'b1}})
              fault <= 1'b1;
          end
        end
        ST_DONE: begin
          if (Start) begin
            pc    <= StartAddr;
            fault <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign InstAddress = pc;
  assign FetchValid  = (state == ST_RUN);
  assign Ack         = (state == ST_DONE);
  assign Fault       = fault;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl.
// Build with FETCH_WATCHDOG_EN to exercise the watchdog with MAXCYC=16.
module tb_inst_fetch_ctrl;

  localparam int A  = 10;
  localparam int OW = 8;
`ifdef FETCH_WATCHDOG_EN
  localparam int MAXCYC = 16;
`else
  localparam int MAXCYC = 4096;
`endif

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic [A-1:0]  StartAddr;
  logic          Stall;
  logic          Halt;
  logic          BranchAbs;
  logic [A-1:0]  Target;
  logic          BranchRel;
  logic [OW-1:0] Offset;
  logic [A-1:0]  InstAddress;
  logic          FetchValid;
  logic          Ack;
  logic          Fault;
  logic          Timeout;

  int checkCount = 0;
  int errorCount = 0;
  int runCycles;

  inst_fetch_ctrl #(.A(A), .OW(OW), .MAXCYC(MAXCYC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .BranchAbs(BranchAbs), .Target(Target),
    .BranchRel(BranchRel), .Offset(Offset), .InstAddress(InstAddress),
    .FetchValid(FetchValid), .Ack(Ack), .Fault(Fault), .Timeout(Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present one cycle of requests, clock it in, then drop all pulses.
  task automatic applyStimulus(input logic st, input int saddr, input logic stl,
                               input logic hlt, input logic babs, input int tgt,
                               input logic brel, input int off);
    Start     = st;
    StartAddr = A'(saddr);
    Stall     = stl;
    Halt      = hlt;
    BranchAbs = babs;
    Target    = A'(tgt);
    BranchRel = brel;
    Offset    = OW'(off);
    @(posedge Clk);
    #1;
    Start = 0; Stall = 0; Halt = 0; BranchAbs = 0; BranchRel = 0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1; Start = 0; StartAddr = '0; Stall = 0; Halt = 0;
    BranchAbs = 0; Target = '0; BranchRel = 0; Offset = '0;
    #12;
    checkOutput("rst_addr", InstAddress, 0);
    checkOutput("rst_valid", FetchValid, 0);
    checkOutput("rst_ack", Ack, 0);
    checkOutput("rst_fault", Fault, 0);
    checkOutput("rst_timeout", Timeout, 0);
    #3 Reset = 0;
    @(posedge Clk); #1;

    // Sequential fetch from 5, then halt at 8
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("seq_first", InstAddress, 5);
    checkOutput("seq_valid", FetchValid, 1);
    checkOutput("seq_ack", Ack, 0);
    idleCycle();
    checkOutput("seq_6", InstAddress, 6);
    idleCycle();
    checkOutput("seq_7", InstAddress, 7);
    idleCycle();
    checkOutput("seq_8", InstAddress, 8);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("halt_ack", Ack, 1);
    checkOutput("halt_valid", FetchValid, 0);
    checkOutput("halt_addr", InstAddress, 8);

    // Absolute and relative branches
    applyStimulus(1, 20, 0, 0, 0, 0, 0, 0);
    checkOutput("br_start", InstAddress, 20);
    checkOutput("br_ack_fall", Ack, 0);
    applyStimulus(0, 0, 0, 0, 1, 100, 0, 0);
    checkOutput("br_abs", InstAddress, 100);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 8'hFD);
    checkOutput("br_rel_neg", InstAddress, 97);
    applyStimulus(1, 1000, 0, 0, 0, 0, 0, 0);
    checkOutput("br_restart", InstAddress, 1000);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 127);
    checkOutput("br_rel_wrap", InstAddress, 103);
    checkOutput("br_rel_nofault", Fault, 0);

    // Priority: stall over branch, halt over branch, DONE ignores branches
    applyStimulus(1, 40, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 3, 0, 0);
    checkOutput("pri_stall", InstAddress, 40);
    applyStimulus(0, 0, 0, 0, 1, 3, 0, 0);
    checkOutput("pri_abs", InstAddress, 3);
    applyStimulus(0, 0, 0, 1, 1, 50, 0, 0);
    checkOutput("pri_halt_ack", Ack, 1);
    checkOutput("pri_halt_addr", InstAddress, 3);
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 0);
    checkOutput("done_ignore_addr", InstAddress, 3);
    checkOutput("done_ignore_ack", Ack, 1);

    // Sequential wrap sets the sticky fault
    applyStimulus(1, 1022, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_1022", InstAddress, 1022);
    checkOutput("wrap_fault0", Fault, 0);
    idleCycle();
    checkOutput("wrap_1023", InstAddress, 1023);
    checkOutput("wrap_fault1", Fault, 0);
    idleCycle();
    checkOutput("wrap_0", InstAddress, 0);
    checkOutput("wrap_fault2", Fault, 1);
    idleCycle();
    checkOutput("wrap_1", InstAddress, 1);
    checkOutput("wrap_sticky", Fault, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("wrap_halt_ack", Ack, 1);
    checkOutput("wrap_halt_fault", Fault, 1);
    applyStimulus(1, 9, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_restart_fault", Fault, 0);
    checkOutput("wrap_restart_ack", Ack, 0);
    checkOutput("wrap_restart_addr", InstAddress, 9);
    checkOutput("wrap_timeout", Timeout, 0);

    // Asynchronous reset in the middle of a cycle
    applyStimulus(1, 300, 0, 0, 0, 0, 0, 0);
    checkOutput("arst_pre", InstAddress, 300);
    #3 Reset = 1;
    #1;
    checkOutput("arst_addr", InstAddress, 0);
    checkOutput("arst_valid", FetchValid, 0);
    checkOutput("arst_ack", Ack, 0);
    #1 Reset = 0;
    @(posedge Clk); #1;
    checkOutput("arst_idle", FetchValid, 0);
    applyStimulus(1, 12, 0, 0, 0, 0, 0, 0);
    checkOutput("arst_resume", InstAddress, 12);
    checkOutput("arst_resume_valid", FetchValid, 1);
    idleCycle();
    checkOutput("arst_resume_next", InstAddress, 13);

    // Long run with toggling stall, never halted
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    runCycles = FetchValid ? 1 : 0;
`ifdef FETCH_WATCHDOG_EN
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, i % 2, 0, 0, 0, 0, 0);
      if (FetchValid) runCycles++;
    end
    checkOutput("wd_run_cycles", runCycles, 16);
    checkOutput("wd_ack", Ack, 1);
    checkOutput("wd_timeout", Timeout, 1);
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0);
    checkOutput("wd_restart_timeout", Timeout, 0);
    checkOutput("wd_restart_valid", FetchValid, 1);
`else
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(0, 0, i % 2, 0, 0, 0, 0, 0);
      if (FetchValid) runCycles++;
    end
    checkOutput("nowd_run_cycles", runCycles, 1001);
    checkOutput("nowd_valid", FetchValid, 1);
    checkOutput("nowd_ack", Ack, 0);
    checkOutput("nowd_timeout", Timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
